// File: rtl/spy_delay_sensor_if.sv
// Handshake/result bundle between the delay-line sensor and its requester.
// master drives requests and external taps; slave (the sensor) returns status and results.
interface spy_delay_sensor_if #(
  parameter int unsigned NTAPS = 10,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ACC_W = 12
);
  logic             start;
  logic             ext_sel;
  logic [NTAPS-1:0] ext_taps;
  logic             busy;
  logic             sample_valid;
  logic [CNT_W-1:0] sample_count;
  logic             result_valid;
  logic [ACC_W-1:0] result;

  modport master (
    output start, ext_sel, ext_taps,
    input  busy, sample_valid, sample_count, result_valid, result
  );

  modport slave (
    input  start, ext_sel, ext_taps,
    output busy, sample_valid, sample_count, result_valid, result
  );
endinterface

// File: rtl/spy_delay_sensor.sv
// Tapped inverting delay-line sensor: precharge, launch, capture, decode, accumulate.
// Optional macro SPY_DELAY_BUBBLE_FIX_EN: popcount decode instead of leading-ones length.
module spy_delay_sensor #(
  parameter int unsigned STAGES     = 50,
  parameter int unsigned TAP_STRIDE = 5,
  parameter int unsigned SAMPLES    = 16,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned ACC_W      = 12
) (
  input logic               clk,
  input logic               rst,
  spy_delay_sensor_if.slave bus
);

  localparam int unsigned NTAPS = STAGES / TAP_STRIDE;
  localparam int unsigned CNT_W = $clog2(NTAPS + 1);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned SMP_W = $clog2(SAMPLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    LAUNCH    = 3'd2,
    CAPTURE   = 3'd3,
    DECODE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_n;

  logic              launch_q;
  logic [SET_W-1:0]  settle_cnt;
  logic [SMP_W-1:0]  sample_cnt;
  logic [ACC_W-1:0]  acc;

  logic [NTAPS-1:0]  tap_c;
  logic [NTAPS-1:0]  prech_mask;
  logic [NTAPS-1:0]  tap_q;
  logic [NTAPS-1:0]  reached_q;
  logic [CNT_W-1:0]  count_c;

  logic              busy_q;
  logic              sample_valid_q;
  logic [CNT_W-1:0]  sample_count_q;
  logic              result_valid_q;
  logic [ACC_W-1:0]  result_q;

  // Inverter chain; each stage kept so the edge genuinely propagates through silicon.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    (* keep *) logic stage_out;
    if (k == 0) begin : g_first
      assign stage_out = ~launch_q;
    end else begin : g_next
      assign stage_out = ~g_stage[k-1].stage_out;
    end
  end

  // Tap i is stage (i+1)*TAP_STRIDE; odd stages idle high while the input is held low.
  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    assign tap_c[i]      = g_stage[(i+1)*TAP_STRIDE-1].stage_out;
    assign prech_mask[i] = 1'(((i + 1) * TAP_STRIDE) % 2);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (bus.start) state_n = PRECHARGE;
      PRECHARGE: if (settle_cnt == SET_W'(SETTLE - 1)) state_n = LAUNCH;
      LAUNCH:    state_n = CAPTURE;
      CAPTURE:   state_n = DECODE;
      DECODE:    state_n = (sample_cnt == SMP_W'(SAMPLES - 1)) ? DONE : PRECHARGE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

`ifdef SPY_DELAY_BUBBLE_FIX_EN
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      count_c = count_c + CNT_W'(reached_q[i]);
    end
  end
`else
  logic run_c;

  // Thermometer length: stop counting at the first tap the edge did not reach.
  always_comb begin
    count_c = '0;
    run_c   = 1'b1;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      run_c   = run_c & reached_q[i];
      count_c = count_c + CNT_W'(run_c);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      launch_q       <= 1'b0;
      settle_cnt     <= '0;
      sample_cnt     <= '0;
      acc            <= '0;
      tap_q          <= '0;
      reached_q      <= '0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_count_q <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      // Chain input is high only for the single LAUNCH cycle.
      launch_q       <= (state_n == LAUNCH);
      settle_cnt     <= (state == PRECHARGE) ? settle_cnt + SET_W'(1) : '0;
      sample_valid_q <= (state == DECODE);
      result_valid_q <= (state == DONE);

      if (state == LAUNCH) tap_q <= tap_c;

      if (state == CAPTURE) begin
        reached_q <= bus.ext_sel ? bus.ext_taps : (tap_q ^ prech_mask);
      end

      if (state == IDLE && bus.start) begin
        acc        <= '0;
        sample_cnt <= '0;
        busy_q     <= 1'b1;
      end else if (state == DECODE) begin
        sample_count_q <= count_c;
        acc            <= acc + ACC_W'(count_c);
        sample_cnt     <= sample_cnt + SMP_W'(1);
      end else if (state == DONE) begin
        result_q <= acc;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_count = sample_count_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_spy_delay_sensor.sv
// Scoreboard bench for spy_delay_sensor: a reference model queues expected samples/results,
// an independent negedge monitor compares them as the DUT presents them.
module tb_spy_delay_sensor;
  localparam int STAGES     = 50;
  localparam int TAP_STRIDE = 5;
  localparam int SAMPLES    = 16;
  localparam int SETTLE     = 4;
  localparam int ACC_W      = 12;
  localparam int NTAPS      = STAGES / TAP_STRIDE;
  localparam int CNT_W      = $clog2(NTAPS + 1);
  localparam int PER        = SETTLE + 3;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   held = 0;
  bit   armed = 1'b0;
  exp_t sq[$];
  exp_t rq[$];

  spy_delay_sensor_if #(.NTAPS(NTAPS), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  spy_delay_sensor #(
    .STAGES(STAGES), .TAP_STRIDE(TAP_STRIDE), .SAMPLES(SAMPLES),
    .SETTLE(SETTLE), .ACC_W(ACC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Zero-delay chain: every tap has flipped by capture time, so all bits read as reached.
  function automatic int ref_count(input bit sel, input logic [NTAPS-1:0] taps);
    logic [NTAPS-1:0] r;
    int n;
    r = sel ? taps : '1;
`ifdef SPY_DELAY_BUBBLE_FIX_EN
    n = $countones(r);
`else
    n = 0;
    while (n < NTAPS && r[n] == 1'b1) n++;
`endif
    return n;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (armed && !rst) begin
      if (rq.size() != 0) check("busy_running", int'(bus.busy), bus.result_valid ? 0 : 1);
      else                check("busy_idle", int'(bus.busy), 0);

      if (bus.sample_valid) begin
        if (sq.size() == 0) begin
          check("spurious_sample_valid", int'(bus.sample_valid), 0);
        end else begin
          e = sq.pop_front();
          check("sample_count", int'(bus.sample_count), e.val);
          check("sample_cycle", cyc, e.cyc);
        end
      end

      if (bus.result_valid) begin
        if (rq.size() == 0) begin
          check("spurious_result_valid", int'(bus.result_valid), 0);
        end else begin
          e = rq.pop_front();
          check("result", int'(bus.result), e.val);
          check("result_cycle", cyc, e.cyc);
          held = e.val;
        end
      end else begin
        check("result_held", int'(bus.result), held);
      end
    end
  end

  task automatic measure(input bit sel, input logic [NTAPS-1:0] taps, input bit spurious);
    int s;
    int n;
    @(posedge clk); #1;
    bus.ext_sel  = sel;
    bus.ext_taps = taps;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s = cyc;
    n = ref_count(sel, taps);
    for (int k = 0; k < SAMPLES; k++) sq.push_back('{cyc: s + PER * (k + 1), val: n});
    rq.push_back('{cyc: s + 1 + SAMPLES * PER, val: n * SAMPLES});
    for (int i = 1; i <= 300 && (sq.size() != 0 || rq.size() != 0); i++) begin
      @(posedge clk); #1;
      bus.start = spurious && (i == 5 || i == 50);
    end
    bus.start = 1'b0;
    if (sq.size() != 0 || rq.size() != 0) begin
      check("measurement_timeout", sq.size() + rq.size(), 0);
      sq.delete();
      rq.delete();
    end
  endtask

  task automatic abort_run();
    int s;
    int n;
    @(posedge clk); #1;
    bus.ext_sel  = 1'b1;
    bus.ext_taps = NTAPS'(10'b0000011111);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s = cyc;
    n = ref_count(1'b1, bus.ext_taps);
    for (int k = 0; k < SAMPLES; k++) sq.push_back('{cyc: s + PER * (k + 1), val: n});
    rq.push_back('{cyc: s + 1 + SAMPLES * PER, val: n * SAMPLES});
    // Third sample's precharge window is cycles 2*PER .. 2*PER+SETTLE-1 after the start edge.
    repeat (2 * PER + 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sq.delete();
    rq.delete();
    held = 0;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_result", int'(bus.result), 0);
    check("abort_launch_q", int'(dut.launch_q), 0);
    check("abort_sample_valid", int'(bus.sample_valid), 0);
    check("abort_result_valid", int'(bus.result_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NTAPS-1:0] t;
    bus.start    = 1'b0;
    bus.ext_sel  = 1'b1;
    bus.ext_taps = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_sample_valid", int'(bus.sample_valid), 0);
    check("reset_sample_count", int'(bus.sample_count), 0);
    check("reset_result_valid", int'(bus.result_valid), 0);
    check("reset_result", int'(bus.result), 0);
    check("reset_launch_q", int'(dut.launch_q), 0);
    armed = 1'b1;

    measure(1'b1, NTAPS'(10'b0000011111), 1'b0);
    measure(1'b1, NTAPS'(10'b0001101111), 1'b0);
    measure(1'b1, NTAPS'(0), 1'b0);
    measure(1'b1, '1, 1'b0);
    measure(1'b0, NTAPS'($urandom), 1'b0);
    measure(1'b1, NTAPS'(10'b0000000111), 1'b1);
    measure(1'b1, NTAPS'(10'b0000111111), 1'b0);
    abort_run();
    measure(1'b1, NTAPS'(10'b0000011111), 1'b0);
    for (int r = 0; r < 4; r++) begin
      t = NTAPS'($urandom);
      measure(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)));
    end
    repeat (20) @(posedge clk);
    if (sq.size() != 0 || rq.size() != 0) check("leftover_expectations", sq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spy_delay_sensor.md
Name: spy_delay_sensor

Overview:
- Parametrised delay-line sensor. Built around a configurable chain of inverting delay stages.
- Per measurement: precharges the chain, launches a rising edge, captures tapped stage outputs one clock later, decodes how far the edge travelled, and accumulates over a programmable number of samples.
- Sits between the spy delay-path chains and the readout logic; replaces fixed-length chains with a measured, handshaked result.

Parameters:
- STAGES, 50, number of inverting delay stages in the chain.
- TAP_STRIDE, 5, a tap is taken every TAP_STRIDE stages; NTAPS = STAGES/TAP_STRIDE (STAGES must be a multiple).
- SAMPLES, 16, launches accumulated per measurement (>=1).
- SETTLE, 4, precharge cycles per sample (>=1).
- ACC_W, 12, accumulator/result width; must hold NTAPS*SAMPLES.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ext_sel  in  1  1 = decode ext_taps instead of chain taps (calibration/bench).
- ext_taps  in  NTAPS  pre-normalised "reached" bits, bit 0 nearest chain input.
- busy  out  1  high from the cycle after accepted start until result_valid.
- sample_valid  out  1  one-cycle pulse per decoded sample.
- sample_count  out  CNT_W=clog2(NTAPS+1)  decoded count of the latest sample.
- result_valid  out  1  one-cycle pulse, measurement complete.
- result  out  ACC_W  sum of the SAMPLES counts; held until the next result_valid.

Behaviour:
- Chain: STAGES inverting stages in series, each marked keep so synthesis cannot collapse it. Chain input is driven by a register, launch_q.
- Tap i = output of stage (i+1)*TAP_STRIDE (1-based).
- Normalisation: reached_i = tap_i XOR precharge level, where precharge level = 1 when the stage number is odd, else 0.
- ext_sel=1: reached = ext_taps directly, no polarity correction.
- Reset: state IDLE, launch_q=0, busy=0, sample_valid=0, result_valid=0, sample_count=0, result=0, accumulator and counters=0.
- States: IDLE, PRECHARGE, LAUNCH, CAPTURE, DECODE, DONE.
- IDLE: launch_q=0. On start=1, clear accumulator and sample counter, go to PRECHARGE; busy=1 from the next cycle.
- PRECHARGE: launch_q=0 for SETTLE cycles, then LAUNCH.
- LAUNCH: launch_q=1 for 1 cycle. Taps are registered on the edge ending this cycle.
- CAPTURE: register the reached vector (ext_sel selects the source); 1 cycle.
- DECODE: compute count, write sample_count, pulse sample_valid, add count to accumulator (zero-extended to ACC_W), increment sample counter, drive launch_q=0.
  - If sample counter reaches SAMPLES: go to DONE.
  - Else: go to PRECHARGE.
- DONE: result<=accumulator, result_valid=1, busy=0 in this cycle; return to IDLE next cycle.
- Per-sample cost: SETTLE+3 cycles. result_valid is asserted exactly 1+SAMPLES*(SETTLE+3) cycles after the start edge (defaults: 113).
- Default decode: count = number of consecutive reached bits starting at bit 0 (thermometer leading-ones length); range 0..NTAPS.
- start while busy is ignored; no queueing.
- rst at any cycle aborts the measurement; all outputs take reset values on the next edge; result is cleared.
- Accumulator cannot overflow when ACC_W meets the parameter rule. No saturation logic.

Optional Feature:
- Macro SPY_DELAY_BUBBLE_FIX_EN.
- Defined: count = popcount of the reached vector, which tolerates metastability bubbles in the thermometer code.
- Undefined: leading-ones decode as above.
- Latency is identical in both builds.

Test Plan:
- ext_sel=1, ext_taps=10'b0000011111, defaults, one start → 16 sample_valid pulses each with sample_count=5; result=80; result_valid at cycle 113 after start.
- ext_taps=10'b0001101111 → without macro: count=4, result=64. With SPY_DELAY_BUBBLE_FIX_EN: count=6, result=96.
- ext_taps all 0 → result=0; ext_taps all 1 → count=10, result=160.
- ext_sel=0, zero-delay simulation → all normalised taps reached after launch; count=10, result=160 (checks polarity correction).
- start pulsed again at cycles 5 and 50 of a running measurement → ignored; exactly one result_valid, value unchanged; a start after DONE runs a full new measurement.
- rst asserted during the 3rd PRECHARGE → next cycle busy=0, result=0, launch_q=0; a following start yields a full 113-cycle measurement with the correct result.
